clk_tick_scheduler: RTL and testbench

//  Shares one prescaler among NUM_CH independently programmable clock-enable channels.

---
 rtl/clk_tick_scheduler.sv | 116 +++++++++++
 tb/tb_clk_tick_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module     : clk_tick_scheduler
// Description: One shared prescaler drives NUM_CH programmable 1-cycle
//              clock-enable channels, with shadowed runtime divisor loads.
//              Optional CLKDIV_SCHED_TOGGLE_EN adds 50% duty clk_out toggles.
// Revision   : 1.0 - initial release
// ============================================================================
module clk_tick_scheduler #(
  parameter int PRESCALE = 50000,
  parameter int NUM_CH   = 4,
  parameter int DIV_W    = 16,
  parameter int CH_W     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              base_tick,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] cfg_pend,
  output logic [NUM_CH-1:0] clk_out
);

  localparam int            PW   = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
    end else if (run) begin
      pcnt <= (pcnt == PMAX) ? '0 : pcnt + PW'(1);
    end
  end

  assign base_tick = run & (pcnt == PMAX);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] act_div;
    logic [DIV_W-1:0] shadow;
    logic [DIV_W-1:0] ccnt;
    logic             pend;
    logic             tick_r;
    logic             sel;
    logic             enabled;
    logic             at_end;
    logic             wrap;

    assign sel     = cfg_we & (cfg_ch == CH_W'(i));
    assign enabled = (act_div != '0);
    assign at_end  = (ccnt == act_div - DIV_W'(1));
    assign wrap    = base_tick & enabled & at_end;

    // A same-cycle write is ordered last so it keeps pend set over the apply.
    always_ff @(posedge clk) begin
      if (rst) begin
        act_div <= '0;
        shadow  <= '0;
        ccnt    <= '0;
        pend    <= 1'b0;
        tick_r  <= 1'b0;
      end else begin
        tick_r <= wrap;
        if (!enabled) begin
          ccnt <= '0;
          if (pend) begin
            act_div <= shadow;
            pend    <= 1'b0;
          end
        end else if (base_tick) begin
          if (at_end) begin
            ccnt <= '0;
            if (pend) begin
              act_div <= shadow;
              pend    <= 1'b0;
            end
          end else begin
            ccnt <= ccnt + DIV_W'(1);
          end
        end
        if (sel) begin
          shadow <= cfg_div;
          pend   <= 1'b1;
        end
      end
    end

    assign tick[i]     = tick_r;
    assign cfg_pend[i] = pend;

`ifdef CLKDIV_SCHED_TOGGLE_EN
    logic tog;

    // Toggle on the same edge that registers the tick; a zero divisor forces low.
    always_ff @(posedge clk) begin
      if (rst) begin
        tog <= 1'b0;
      end else if (!enabled || (wrap && pend && (shadow == '0))) begin
        tog <= 1'b0;
      end else if (wrap) begin
        tog <= ~tog;
      end
    end

    assign clk_out[i] = tog;
`else
    assign clk_out[i] = 1'b0;
`endif
  end : g_ch

endmodule
`default_nettype wire

// File: tb/tb_clk_tick_scheduler.sv
`default_nettype none
// Directed table plus multi-cycle sequences for clk_tick_scheduler
// at PRESCALE=4, NUM_CH=4, DIV_W=8.
module tb_clk_tick_scheduler;

`ifdef CLKDIV_SCHED_TOGGLE_EN
  localparam logic TOG = 1'b1;
`else
  localparam logic TOG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_div = '0;
  logic       base_tick;
  logic [3:0] tick;
  logic [3:0] cfg_pend;
  logic [3:0] clk_out;

  clk_tick_scheduler #(
    .PRESCALE(4), .NUM_CH(4), .DIV_W(8), .CH_W(2)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .base_tick(base_tick), .tick(tick),
    .cfg_pend(cfg_pend), .clk_out(clk_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       run;
    logic       we;
    logic [1:0] ch;
    logic [7:0] div;
    logic       bt;
    logic [3:0] tk;
    logic [3:0] pd;
  } vec_t;

  vec_t tbl[25];
  int   nvec = 0;
  int   nerr = 0;
  int   cyc  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
  task automatic next();
    @(negedge clk);
    cyc++;
  endtask

  task automatic step();
    next();
    cfg_we = 1'b0;
    #1;
  endtask

  task automatic step_wr(input logic [1:0] ch, input logic [7:0] div);
    next();
    cfg_we = 1'b1; cfg_ch = ch; cfg_div = div;
    #1;
  endtask

  task automatic step_run(input logic r);
    next();
    cfg_we = 1'b0; run = r;
    #1;
  endtask

  task automatic do_reset();
    next();
    rst = 1'b1; cfg_we = 1'b0; run = 1'b1;
    repeat (2) next();
    next();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_tick(input int ch, input int budget, output int t);
    t = -1;
    for (int k = 0; k < budget; k++) begin
      step();
      if (tick[ch]) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) chk("tick timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int tA, tB, tC, tD, cnt, flag;

    //            run we ch div   bt  tick   pend
    tbl[0]  = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'h0};
    tbl[1]  = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'h0};
    tbl[2]  = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'h0};
    tbl[3]  = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b1, 4'h0, 4'h0};
    tbl[4]  = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'h0};
    tbl[5]  = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'h0};
    tbl[6]  = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'h0};
    tbl[7]  = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b1, 4'h0, 4'h0};
    tbl[8]  = '{1'b1, 1'b1, 2'd0, 8'd3, 1'b0, 4'h0, 4'h0};
    tbl[9]  = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'h1};
    tbl[10] = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'h0};
    tbl[11] = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b1, 4'h0, 4'h0};
    tbl[12] = '{1'b1, 1'b1, 2'd1, 8'd2, 1'b0, 4'h0, 4'h0};
    tbl[13] = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'h2};
    tbl[14] = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'h0};
    tbl[15] = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b1, 4'h0, 4'h0};
    tbl[16] = '{1'b1, 1'b0, 2'd2, 8'd5, 1'b0, 4'h0, 4'h0};
    tbl[17] = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'h0};
    tbl[18] = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'h0};
    tbl[19] = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b1, 4'h0, 4'h0};
    tbl[20] = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h3, 4'h0};
    tbl[21] = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'h0};
    tbl[22] = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'h0};
    tbl[23] = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b1, 4'h0, 4'h0};
    tbl[24] = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'h0};

    rst = 1'b1;
    repeat (3) next();
    for (int k = 0; k < 25; k++) begin
      next();
      rst = 1'b0;
      run = tbl[k].run; cfg_we = tbl[k].we; cfg_ch = tbl[k].ch; cfg_div = tbl[k].div;
      #1;
      chk($sformatf("row%0d base_tick", k), 32'(base_tick), 32'(tbl[k].bt));
      chk($sformatf("row%0d tick", k), 32'(tick), 32'(tbl[k].tk));
      chk($sformatf("row%0d cfg_pend", k), 32'(cfg_pend), 32'(tbl[k].pd));
    end

    // Running ch1 div=2, reprogrammed to 5 mid-period
    do_reset();
    step_wr(2'd1, 8'd2);
    wait_tick(1, 40, tA);
    wait_tick(1, 20, tB);
    chk("ch1 period div2", 32'(tB - tA), 32'd8);
    step();
    step_wr(2'd1, 8'd5);
    step();
    chk("ch1 pend after write", 32'(cfg_pend[1]), 32'd1);
    tC = -1; flag = 1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (tick[1]) begin tC = cyc; break; end
      if (!cfg_pend[1]) flag = 0;
    end
    chk("ch1 last old period", 32'(tC - tB), 32'd8);
    chk("ch1 pend held until tick", 32'(flag), 32'd1);
    chk("ch1 pend cleared at tick", 32'(cfg_pend[1]), 32'd0);
    wait_tick(1, 40, tD);
    chk("ch1 period div5", 32'(tD - tC), 32'd20);

    // ch0 div=3 frozen by run=0 for 7 cycles mid-period
    do_reset();
    step_wr(2'd0, 8'd3);
    wait_tick(0, 40, tA);
    wait_tick(0, 20, tB);
    chk("ch0 period div3", 32'(tB - tA), 32'd12);
    cnt = 0;
    repeat (5) begin step(); cnt += int'(tick[0]); end
    step_run(1'b0);
    flag = int'(base_tick);
    repeat (6) begin step(); flag += int'(base_tick); end
    step_run(1'b1);
    chk("no base_tick while frozen", 32'(flag), 32'd0);
    chk("no tick in frozen period", 32'(cnt), 32'd0);
    tC = -1;
    if (tick[0]) tC = cyc; else wait_tick(0, 30, tC);
    chk("ch0 delayed by freeze", 32'(tC - tB), 32'd19);
    wait_tick(0, 20, tD);
    chk("ch0 period after freeze", 32'(tD - tC), 32'd12);

    // ch3 write landing exactly in a wrap cycle
    do_reset();
    step_wr(2'd3, 8'd2);
    wait_tick(3, 40, tA);
    step();
    step_wr(2'd3, 8'd3);
    repeat (4) step();
    step_wr(2'd3, 8'd1);
    chk("ch3 write in wrap cycle", 32'(base_tick), 32'd1);
    chk("ch3 pend before wrap", 32'(cfg_pend[3]), 32'd1);
    step();
    chk("ch3 tick after wrap", 32'(tick[3]), 32'd1);
    chk("ch3 pend survives wrap", 32'(cfg_pend[3]), 32'd1);
    tB = cyc;
    wait_tick(3, 30, tC);
    chk("ch3 period div3", 32'(tC - tB), 32'd12);
    chk("ch3 pend cleared", 32'(cfg_pend[3]), 32'd0);
    wait_tick(3, 20, tD);
    chk("ch3 period div1", 32'(tD - tC), 32'd4);

    // ch2 div=1 square wave, then disabled
    do_reset();
    step_wr(2'd2, 8'd1);
    wait_tick(2, 30, tA);
    chk("clk_out2 at tick", 32'(clk_out[2]), 32'(TOG));
    cnt = int'(clk_out[2]);
    repeat (3) begin step(); cnt += int'(clk_out[2]); end
    step();
    chk("ch2 tick div1", 32'(tick[2]), 32'd1);
    chk("clk_out2 low half", 32'(clk_out[2]), 32'd0);
    repeat (3) begin step(); cnt += int'(clk_out[2]); end
    chk("clk_out2 high cycles", 32'(cnt), TOG ? 32'd4 : 32'd0);
    step();
    chk("clk_out2 rises again", 32'(clk_out[2]), 32'(TOG));
    step_wr(2'd2, 8'd0);
    repeat (3) step();
    chk("ch2 final tick", 32'(tick[2]), 32'd1);
    chk("clk_out2 forced low", 32'(clk_out[2]), 32'd0);
    chk("ch2 pend applied", 32'(cfg_pend[2]), 32'd0);
    cnt = 0;
    repeat (16) begin step(); cnt += int'(tick[2]) + int'(clk_out[2]); end
    chk("ch2 silent when disabled", 32'(cnt), 32'd0);

    // Reset mid-run with a pending write and a wrap about to fire
    do_reset();
    step_wr(2'd0, 8'd1);
    step_wr(2'd1, 8'd2);
    wait_tick(0, 30, tA);
    step();
    step_wr(2'd0, 8'd3);
    next();
    cfg_we = 1'b0; rst = 1'b1;
    #1;
    chk("pend before rst", 32'(cfg_pend[0]), 32'd1);
    next();
    rst = 1'b0;
    #1;
    chk("rst tick", 32'(tick), 32'd0);
    chk("rst cfg_pend", 32'(cfg_pend), 32'd0);
    chk("rst clk_out", 32'(clk_out), 32'd0);
    chk("rst base_tick", 32'(base_tick), 32'd0);
    cnt = 0;
    repeat (24) begin step(); cnt += int'(tick != 4'h0) + int'(cfg_pend != 4'h0); end
    chk("pending discarded by rst", 32'(cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
